sll_iter: RTL and testbench

Iterative 16-bit left shifter/rotator for the execute stage, the left-direction counterpart of the datapath's combinational right-shift stages. It accepts an operand, a 4-bit shift amount and an operation code through a valid/ready handshake, then applies one binary-weighted shift stage per clock (1, 2, 4, 8), LSB of the shift amount first. Shifting stops after the highest set bit of the shift amount. The result is returned through a second valid/ready handshake, which lets slow or stalled consumers hold it.

---
 rtl/sll_pkg.sv | 30 +++
 rtl/mux2_1.sv | 11 +
 rtl/sll_stage.sv | 37 +++
 rtl/sll_iter.sv | 99 +++++++++
 tb/tb_sll_iter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sll_pkg.sv
// Shared encodings and helpers for the iterative left shifter/rotator.
package sll_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_ROL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        logic               op;
    } sll_req_t;

    // True when stage k is the last one needed: no higher shift-amount bit is set.
    function automatic logic last_stage(input logic [SHAMT_W-1:0] shamt,
                                        input logic [1:0]         k);
        logic [2:0] kp1;
        kp1 = {1'b0, k} + 3'd1;
        return (k == 2'd3) || ((shamt >> kp1) == '0);
    endfunction

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 mux, the leaf cell of the shift stage.
module mux2_1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/sll_stage.sv
// One binary-weighted left shift/rotate layer: shifts by 2^k when en is set.
module sll_stage
    import sll_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       k,
    input  logic             en,
    input  logic             op,
    output logic [WIDTH-1:0] dout
);

    localparam int NSTAGE = SHAMT_W;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // cand[j] is what lands in bit i after a shift by 2^j.
        logic [NSTAGE-1:0] cand;

        for (genvar j = 0; j < NSTAGE; j++) begin : g_cand
            if (i >= (1 << j)) begin : g_in
                assign cand[j] = din[i - (1 << j)];
            end else begin : g_wrap
                // Low bits either wrap from the top (ROL) or fill with zero (SLL).
                assign cand[j] = (op == OP_ROL) ? din[i - (1 << j) + WIDTH] : 1'b0;
            end
        end

        mux2_1 u_mux (
            .a   (din[i]),
            .b   (cand[k]),
            .sel (en),
            .y   (dout[i])
        );
    end

endmodule

// File: rtl/sll_iter.sv
// Iterative 16-bit SLL/ROL: one binary-weighted stage per clock, LSB of shamt first.
module sll_iter
    import sll_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic               op_q;
    logic [1:0]         k_q;
    logic               rdy_q;
    logic [WIDTH-1:0]   stage_out;
    logic               accept;
    logic               last;
    sll_req_t           req;

    assign req    = '{data: in_data, shamt: in_shamt, op: in_op};
    assign last   = last_stage(shamt_q, k_q);

    // rdy_q keeps in_ready low while reset is held and for the release edge.
    assign in_ready  = rdy_q && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;

    // Outputs are gated by DONE so nothing partial is ever visible.
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_valid ? data_q : '0;
    assign out_zero  = out_valid && (data_q == '0);

    sll_stage #(.WIDTH(WIDTH)) u_stage (
        .din  (data_q),
        .k    (k_q),
        .en   (shamt_q[k_q]),
        .op   (op_q),
        .dout (stage_out)
    );

    // State register plus reset-release flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    // Next-state: shamt==0 skips straight to DONE; SHIFT ends after the top set bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (req.shamt == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (last)   state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand capture on accept, then one shift stage per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= OP_SLL;
            k_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q  <= req.data;
                        shamt_q <= req.shamt;
                        op_q    <= req.op;
                        k_q     <= '0;
                    end
                end
                ST_SHIFT: begin
                    data_q <= stage_out;
                    if (!last) k_q <= k_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sll_iter.sv
// Directed bench for sll_iter: hand-computed vectors, latency, backpressure, reset.
module tb_sll_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sll_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one request on a negedge; it is accepted on the following posedge.
    task automatic send(input string tag, input logic [15:0] d, input logic [3:0] s,
                        input logic o);
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_data = d; in_shamt = s; in_op = o;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid, bounded.
    task automatic wait_out(input string tag, input int exp_lat, input logic [15:0] exp_d,
                            input logic exp_z);
        int lat;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 32) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"},       lat,       exp_lat);
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".out_data"},  out_data,  exp_d);
        chk({tag, ".out_zero"},  out_zero,  exp_z);
        chk({tag, ".no_ready"},  in_ready,  0);
    endtask

    // Complete the output handshake and confirm return to IDLE.
    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_valid"}, out_valid, 0);
        chk({tag, ".idle_ready"}, in_ready,  1);
    endtask

    task automatic run_vec(input string tag, input logic [15:0] d, input logic [3:0] s,
                           input logic o, input int lat, input logic [15:0] exp_d,
                           input logic exp_z);
        send(tag, d, s, o);
        wait_out(tag, lat, exp_d, exp_z);
        take(tag);
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data",  out_data,  0);
        chk("rst.out_zero",  out_zero,  0);
        chk("rst.in_ready",  in_ready,  0);
        @(negedge clk) rst_n = 1'b1;

        // tag, data, shamt, op, latency, expected result, expected zero
        run_vec("sll15",   16'h0001, 4'd15, 1'b0, 5, 16'h8000, 1'b0);
        run_vec("rol1",    16'h8001, 4'd1,  1'b1, 2, 16'h0003, 1'b0);
        run_vec("sll0",    16'hABCD, 4'd0,  1'b0, 1, 16'hABCD, 1'b0);
        run_vec("rol0",    16'hABCD, 4'd0,  1'b1, 1, 16'hABCD, 1'b0);
        run_vec("sll12",   16'h00F0, 4'd12, 1'b0, 5, 16'h0000, 1'b1);
        run_vec("rol12",   16'h00F0, 4'd12, 1'b1, 5, 16'h000F, 1'b0);
        run_vec("rol5",    16'h1234, 4'd5,  1'b1, 4, 16'h4682, 1'b0);
        run_vec("sll8",    16'hFFFF, 4'd8,  1'b0, 5, 16'hFF00, 1'b0);
        run_vec("rol10",   16'hF00F, 4'd10, 1'b1, 5, 16'h3FC0, 1'b0);
        run_vec("sll1z",   16'h8000, 4'd1,  1'b0, 2, 16'h0000, 1'b1);

        // Backpressure: hold the result, offer a competing request meanwhile.
        send("bp", 16'h0003, 4'd2, 1'b0);
        wait_out("bp", 3, 16'h000C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                in_valid = 1'b1; in_data = 16'h1234; in_shamt = 4'd4; in_op = 1'b0;
            end
            @(negedge clk);
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.hold_data",  out_data,  16'h000C);
            chk("bp.hold_ready", in_ready,  0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp.idle_valid", out_valid, 0);
        chk("bp.idle_ready", in_ready,  1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out("bp2", 4, 16'h2340, 1'b0);
        take("bp2");

        // Reset during the second SHIFT cycle of a shamt=15 operation.
        send("rst_mid", 16'h0001, 4'd15, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.out_valid", out_valid, 0);
        chk("rst_mid.out_data",  out_data,  0);
        chk("rst_mid.out_zero",  out_zero,  0);
        chk("rst_mid.in_ready",  in_ready,  0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.ready_after", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid.no_result", out_valid, 0);
        end
        run_vec("post_rst", 16'h0001, 4'd15, 1'b0, 5, 16'h8000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
